// File: rtl/aes_key_inv_expand_128.sv
// Iterative AES-128 inverse key schedule.
// Takes the round-10 key and walks the key schedule backwards one round per
// accepted beat. It streams round keys 10..0 and keeps the recovered cipher
// key (round 0) until the next start.
// Optional macro AES_KEY_INV_CACHE_EN adds an 11-entry round-key file with a
// registered read port (rd_idx / rd_key).
//
// Stream handshake: a beat transfers on a rising edge where rk_valid and
// rk_ready are both 1. While rk_valid=1 and rk_ready=0, rk_out and rk_round
// hold steady. rk_valid never drops without a transfer except on reset.

// AES forward S-box, computed as the GF(2^8) inverse followed by the affine map.
module aes_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    logic [7:0] w_x2, w_x4, w_x8, w_x16, w_x32, w_x64, w_x128;
    logic [7:0] w_inv;

    // x^254 == x^-1 in GF(2^8), and 0 maps to 0 as AES requires.
    always_comb begin
        w_x2   = gf_mul(i_byte, i_byte);
        w_x4   = gf_mul(w_x2, w_x2);
        w_x8   = gf_mul(w_x4, w_x4);
        w_x16  = gf_mul(w_x8, w_x8);
        w_x32  = gf_mul(w_x16, w_x16);
        w_x64  = gf_mul(w_x32, w_x32);
        w_x128 = gf_mul(w_x64, w_x64);
        w_inv  = gf_mul(gf_mul(gf_mul(w_x2, w_x4), gf_mul(w_x8, w_x16)),
                        gf_mul(gf_mul(w_x32, w_x64), w_x128));
        o_byte = w_inv
               ^ {w_inv[6:0], w_inv[7]}
               ^ {w_inv[5:0], w_inv[7:6]}
               ^ {w_inv[4:0], w_inv[7:5]}
               ^ {w_inv[3:0], w_inv[7:4]}
               ^ 8'h63;
    end
endmodule

module aes_key_inv_expand_128 (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic [127:0] rk_out,
    output logic [3:0]   rk_round,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic         busy,
    output logic         done,
    output logic [127:0] key0_out
`ifdef AES_KEY_INV_CACHE_EN
    ,
    input  logic [3:0]   rd_idx,
    output logic [127:0] rd_key
`endif
);
    typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [127:0]  r_key;
    logic [3:0]    r_round;
    logic          r_done;
    logic [127:0]  r_key0;

    logic          w_load;
    logic          w_step;
    logic          w_finish;

    logic [31:0]   w_w0, w_w1, w_w2, w_w3;
    logic [31:0]   w_p0, w_p1, w_p2, w_p3;
    logic [31:0]   w_rot;
    logic [31:0]   w_sub;
    logic [7:0]    w_rcon;
    logic [127:0]  w_key_prev;

    function automatic logic [7:0] rcon_of(input logic [3:0] r);
        case (r)
            4'd1:    rcon_of = 8'h01;
            4'd2:    rcon_of = 8'h02;
            4'd3:    rcon_of = 8'h04;
            4'd4:    rcon_of = 8'h08;
            4'd5:    rcon_of = 8'h10;
            4'd6:    rcon_of = 8'h20;
            4'd7:    rcon_of = 8'h40;
            4'd8:    rcon_of = 8'h80;
            4'd9:    rcon_of = 8'h1b;
            4'd10:   rcon_of = 8'h36;
            default: rcon_of = 8'h00;
        endcase
    endfunction

    // One inverse key-schedule step: round r key -> round r-1 key.
    always_comb begin
        w_w0       = r_key[127:96];
        w_w1       = r_key[95:64];
        w_w2       = r_key[63:32];
        w_w3       = r_key[31:0];
        w_p3       = w_w3 ^ w_w2;
        w_p2       = w_w2 ^ w_w1;
        w_p1       = w_w1 ^ w_w0;
        w_rot      = {w_p3[23:0], w_p3[31:24]};
        w_rcon     = rcon_of(r_round);
        w_p0       = w_w0 ^ w_sub ^ {w_rcon, 24'h000000};
        w_key_prev = {w_p0, w_p1, w_p2, w_p3};
    end

    aes_sbox u_sbox3 (.i_byte(w_rot[31:24]), .o_byte(w_sub[31:24]));
    aes_sbox u_sbox2 (.i_byte(w_rot[23:16]), .o_byte(w_sub[23:16]));
    aes_sbox u_sbox1 (.i_byte(w_rot[15:8]),  .o_byte(w_sub[15:8]));
    aes_sbox u_sbox0 (.i_byte(w_rot[7:0]),   .o_byte(w_sub[7:0]));

    // Next-state and datapath control decode.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (rk_ready) begin
                    if (r_round != 4'd0) begin
                        w_step = 1'b1;
                    end else begin
                        w_finish    = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register and key datapath; reset discards any partial run.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_key   <= '0;
            r_round <= '0;
            r_done  <= 1'b0;
            r_key0  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_finish;
            if (w_load) begin
                r_key   <= key_in;
                r_round <= 4'd10;
            end else if (w_step) begin
                r_key   <= w_key_prev;
                r_round <= r_round - 4'd1;
            end
            if (w_finish) begin
                r_key0 <= r_key;
            end
        end
    end

    assign rk_out   = r_key;
    assign rk_round = r_round;
    assign rk_valid = (r_state == S_RUN);
    assign busy     = (r_state == S_RUN);
    assign done     = r_done;
    assign key0_out = r_key0;

`ifdef AES_KEY_INV_CACHE_EN
    logic [127:0] r_file [0:10];
    logic [127:0] r_rd_key;

    // Capture every accepted beat at its round index; registered read port.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 11; i++) begin
                r_file[i] <= '0;
            end
            r_rd_key <= '0;
        end else begin
            if (w_step || w_finish) begin
                r_file[r_round] <= r_key;
            end
            r_rd_key <= (rd_idx <= 4'd10) ? r_file[rd_idx] : '0;
        end
    end

    assign rd_key = r_rd_key;
`else
    // No round-key storage in this build; keys are only available on the stream.
`endif
endmodule

// File: tb/tb_aes_key_inv_expand_128.sv
// Bench for aes_key_inv_expand_128: FIPS-197 A.1 walk, backpressure, start
// while busy, reset mid-run, back-to-back start, and the optional key cache
// (AES_KEY_INV_CACHE_EN).
module tb_aes_key_inv_expand_128;
    // FIPS-197 A.1 key schedule, index = round
    localparam logic [127:0] FIPS_K [0:10] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };
    localparam logic [127:0] ZERO_K10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
    localparam logic [127:0] ZERO_K1  = 128'h62636363626363636263636362636363;

    logic         clk;
    logic         rst;
    logic         start;
    logic [127:0] key_in;
    logic [127:0] rk_out;
    logic [3:0]   rk_round;
    logic         rk_valid;
    logic         rk_ready;
    logic         busy;
    logic         done;
    logic [127:0] key0_out;
    logic [3:0]   rd_idx;
    logic [127:0] rd_key;

    // {key_known, round, key}
    logic [132:0] exp_q[$];
    int n_cmp;
    int n_err;
    logic busy_gap;

    aes_key_inv_expand_128 dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .key_in   (key_in),
        .rk_out   (rk_out),
        .rk_round (rk_round),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .busy     (busy),
        .done     (done),
        .key0_out (key0_out)
`ifdef AES_KEY_INV_CACHE_EN
        ,
        .rd_idx   (rd_idx),
        .rd_key   (rd_key)
`endif
    );

`ifndef AES_KEY_INV_CACHE_EN
    assign rd_key = '0;
`endif

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_fips();
        for (int r = 10; r >= 0; r--) begin
            exp_q.push_back({1'b1, 4'(r), FIPS_K[r]});
        end
    endtask

    task automatic push_zero();
        for (int r = 10; r >= 0; r--) begin
            if (r == 10)     exp_q.push_back({1'b1, 4'(r), ZERO_K10});
            else if (r == 1) exp_q.push_back({1'b1, 4'(r), ZERO_K1});
            else if (r == 0) exp_q.push_back({1'b1, 4'(r), 128'h0});
            else             exp_q.push_back({1'b0, 4'(r), 128'h0});
        end
    endtask

    // drive a one-cycle start; afterwards we are at cycle 1 of the run
    task automatic start_run(input logic [127:0] k);
        start  = 1'b1;
        key_in = k;
        tick();
        start  = 1'b0;
        key_in = '0;
    endtask

    task automatic wait_done(input int c0, output int c);
        c = c0;
        while (!done && c < c0 + 100) begin
            tick();
            c++;
        end
        check("done_seen", 128'(done), 128'd1);
    endtask

    task automatic wait_round(input logic [3:0] r);
        int n;
        n = 0;
        while (rk_round != r && n < 50) begin
            tick();
            n++;
            if (!busy) busy_gap = 1'b1;
        end
        check("round_reached", 128'(rk_round), 128'(r));
    endtask

    // scoreboard: every transferred beat is matched against the expected queue
    always @(negedge clk) begin
        logic [132:0] item;
        if (!rst && rk_valid && rk_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_extra_beat", 128'(exp_q.size()), 128'd1);
            end else begin
                item = exp_q.pop_front();
                check($sformatf("beat_round_r%0d", item[131:128]), 128'(rk_round), 128'(item[131:128]));
                if (item[132]) begin
                    check($sformatf("beat_key_r%0d", item[131:128]), rk_out, item[127:0]);
                end
            end
        end
    end

    initial begin
        int c;
        n_cmp    = 0;
        n_err    = 0;
        busy_gap = 1'b0;
        rst      = 1'b1;
        start    = 1'b0;
        key_in   = '0;
        rk_ready = 1'b1;
        rd_idx   = '0;

        // reset state
        repeat (3) tick();
        check("rst_valid", 128'(rk_valid), 128'd0);
        check("rst_busy",  128'(busy), 128'd0);
        check("rst_done",  128'(done), 128'd0);
        check("rst_key0",  key0_out, 128'd0);
        check("rst_rkout", rk_out, 128'd0);
        check("rst_round", 128'(rk_round), 128'd0);
        rst = 1'b0;
        tick();

        // test 1: FIPS A.1, rk_ready tied high
        push_fips();
        start_run(FIPS_K[10]);
        check("t1_busy_c1",  128'(busy), 128'd1);
        check("t1_valid_c1", 128'(rk_valid), 128'd1);
        check("t1_round_c1", 128'(rk_round), 128'd10);
        wait_done(1, c);
        check("t1_done_cycle", 128'(c), 128'd12);
        check("t1_key0", key0_out, FIPS_K[0]);
        check("t1_busy_at_done", 128'(busy), 128'd0);
        tick();
        check("t1_done_pulse", 128'(done), 128'd0);
        check("t1_key0_hold", key0_out, FIPS_K[0]);
        check("t1_sb_drain", 128'(exp_q.size()), 128'd0);

`ifdef AES_KEY_INV_CACHE_EN
        // test 6: read back the cached round keys
        rd_idx = 4'd9;
        tick();
        check("t6_rd9", rd_key, FIPS_K[9]);
        rd_idx = 4'd0;
        tick();
        check("t6_rd0", rd_key, FIPS_K[0]);
        rd_idx = 4'd11;
        tick();
        check("t6_rd11", rd_key, 128'd0);
        rd_idx = 4'd0;
`endif

        // test 2: backpressure at round 9 for 3 cycles
        push_fips();
        start_run(FIPS_K[10]);
        tick();
        c = 2;
        check("t2_round9", 128'(rk_round), 128'd9);
        rk_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            c++;
            check($sformatf("t2_hold_round_%0d", i), 128'(rk_round), 128'd9);
            check($sformatf("t2_hold_key_%0d", i), rk_out, FIPS_K[9]);
            check($sformatf("t2_hold_valid_%0d", i), 128'(rk_valid), 128'd1);
        end
        rk_ready = 1'b1;
        wait_done(c, c);
        check("t2_done_cycle", 128'(c), 128'd15);
        check("t2_key0", key0_out, FIPS_K[0]);
        tick();

        // test 3: start while busy (mid-run and on the round-0 handshake)
        push_fips();
        start_run(FIPS_K[10]);
        busy_gap = 1'b0;
        wait_round(4'd5);
        start  = 1'b1;
        key_in = '0;
        tick();
        start  = 1'b0;
        if (!busy) busy_gap = 1'b1;
        wait_round(4'd0);
        check("t3_busy_held", 128'(busy_gap), 128'd0);
        start  = 1'b1;
        key_in = ZERO_K10;
        tick();
        start  = 1'b0;
        key_in = '0;
        check("t3_done", 128'(done), 128'd1);
        check("t3_key0", key0_out, FIPS_K[0]);
        tick();
        check("t3_late_start_ignored", 128'(busy), 128'd0);
        check("t3_valid_low", 128'(rk_valid), 128'd0);
        check("t3_sb_drain", 128'(exp_q.size()), 128'd0);

        // test 4: reset mid-run at round 4
        push_fips();
        start_run(FIPS_K[10]);
        wait_round(4'd4);
        rst = 1'b1;
        exp_q.delete();
`ifdef AES_KEY_INV_CACHE_EN
        rd_idx = 4'd10;
`endif
        tick();
        check("t4_valid", 128'(rk_valid), 128'd0);
        check("t4_busy",  128'(busy), 128'd0);
        check("t4_done",  128'(done), 128'd0);
        check("t4_key0",  key0_out, 128'd0);
        rst = 1'b0;
`ifdef AES_KEY_INV_CACHE_EN
        tick();
        check("t4_file_cleared", rd_key, 128'd0);
        rd_idx = 4'd0;
`endif
        tick();
        push_fips();
        start_run(FIPS_K[10]);
        wait_done(1, c);
        check("t4_done_cycle", 128'(c), 128'd12);
        check("t4_key0_after", key0_out, FIPS_K[0]);

        // test 5: back-to-back start on the done cycle with the all-zero key
        push_zero();
        start_run(ZERO_K10);
        check("t5_done_pulse", 128'(done), 128'd0);
        check("t5_busy", 128'(busy), 128'd1);
        check("t5_round10", 128'(rk_round), 128'd10);
        wait_done(1, c);
        check("t5_done_cycle", 128'(c), 128'd12);
        check("t5_key0", key0_out, 128'd0);
        check("t5_sb_drain", 128'(exp_q.size()), 128'd0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
